// File: rtl/mem_stage_pkg.sv
// Shared types for the RV32 memory-access stage: bundle layouts, access-size encodings, FSM states.
package mem_stage_pkg;

    localparam int EX_DATA_W  = 80;
    localparam int MEM_DATA_W = 74;

    localparam logic [2:0] MODE_B = 3'b001;
    localparam logic [2:0] MODE_H = 3'b010;
    localparam logic [2:0] MODE_W = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic        memwrite;
        logic        memread;
        logic        regwrite;
        logic [3:0]  memtoreg;
        logic [2:0]  mem_mode;
        logic        mem_read_us;
        logic [31:0] rdata2;
        logic [4:0]  rd;
        logic [31:0] result;
    } ex_mem_t;

    typedef struct packed {
        logic        regwrite;
        logic [3:0]  memtoreg;
        logic [4:0]  rd;
        logic [31:0] result;
        logic [31:0] load_data;
    } mem_wb_t;

    function automatic logic [31:0] word_addr(input logic [31:0] byte_addr);
        return {byte_addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/grant/response port; the stage is master, the memory is slave.
interface mem_stage_if;

    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (output req, we, addr, wstrb, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, we, addr, wstrb, wdata, output gnt, rvalid, rdata);

endinterface

// File: rtl/mem_lsu_align.sv
// Byte-lane logic: store strobes/replication, misalignment check and load lane extraction/extension.
module mem_lsu_align
    import mem_stage_pkg::*;
(
    input  logic [2:0]  mode,
    input  logic [1:0]  addr_lo,
    input  logic        read_us,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,
    output logic        misalign,
    output logic [31:0] load_data
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        case (addr_lo)
            2'd0:    byte_lane = rdata[7:0];
            2'd1:    byte_lane = rdata[15:8];
            2'd2:    byte_lane = rdata[23:16];
            default: byte_lane = rdata[31:24];
        endcase
        half_lane = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    end

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        wstrb     = 4'b1111;
        wdata     = store_data;
        misalign  = |addr_lo;
        load_data = rdata;
        case (mode)
            MODE_B: begin
                wstrb     = 4'b0001 << addr_lo;
                wdata     = {4{store_data[7:0]}};
                misalign  = 1'b0;
                load_data = {{24{byte_lane[7] & ~read_us}}, byte_lane};
            end
            MODE_H: begin
                wstrb     = 4'b0011 << {addr_lo[1], 1'b0};
                wdata     = {2{store_data[15:0]}};
                misalign  = addr_lo[0];
                load_data = {{16{half_lane[15] & ~read_us}}, half_lane};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// RV32 MEM stage: captures the EX bundle, runs one data-memory access at a time and presents MEM->WB.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [EX_DATA_W-1:0]  ex_mem_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    mem_stage_if.master           dmem,
    output logic [MEM_DATA_W-1:0] mem_wb_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  mem_misalign,
    output logic                  mem_err
);

    localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    state_t         state, state_n;
    ex_mem_t        ex_in, ex_q;
    mem_wb_t        wb;
    logic [31:0]    load_data_q;
    logic [WD_W-1:0] wd;

    logic        req_q, we_q;
    logic [31:0] addr_q, wdata_q;
    logic [3:0]  wstrb_q;
    logic        misalign_q, err_q;

    logic        in_access, accept, mem_op_in, start_req, drop;
    logic        done_ok, load_done, wd_hit, timeout_fire;

    logic [2:0]  al_mode;
    logic [1:0]  al_addr_lo;
    logic        al_read_us, al_misalign;
    logic [31:0] al_store_data, al_wdata, al_load;
    logic [3:0]  al_wstrb;

    assign ex_in     = ex_mem_t'(ex_mem_data);
    assign in_access = (state == ST_REQ) || (state == ST_WAIT);
    assign in_ready  = (state == ST_IDLE) || ((state == ST_DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == ST_DONE);

    // While an access is in flight the aligner looks at the captured bundle (load extraction);
    // otherwise it looks at the incoming bundle (strobes and misalignment at accept time).
    assign al_mode       = in_access ? ex_q.mem_mode      : ex_in.mem_mode;
    assign al_addr_lo    = in_access ? ex_q.result[1:0]   : ex_in.result[1:0];
    assign al_read_us    = in_access ? ex_q.mem_read_us   : ex_in.mem_read_us;
    assign al_store_data = in_access ? ex_q.rdata2        : ex_in.rdata2;

    mem_lsu_align u_align (
        .mode       (al_mode),
        .addr_lo    (al_addr_lo),
        .read_us    (al_read_us),
        .store_data (al_store_data),
        .rdata      (dmem.rdata),
        .wstrb      (al_wstrb),
        .wdata      (al_wdata),
        .misalign   (al_misalign),
        .load_data  (al_load)
    );

    assign mem_op_in = ex_in.memread || ex_in.memwrite;
    assign start_req = accept && mem_op_in && !al_misalign;
    assign drop      = accept && mem_op_in && al_misalign;

    // A store finishes on grant; a load needs its data, which may arrive with the grant.
    assign done_ok   = ((state == ST_REQ) && dmem.gnt && (ex_q.memwrite || dmem.rvalid)) ||
                       ((state == ST_WAIT) && dmem.rvalid);
    assign load_done = done_ok && ex_q.memread && !ex_q.memwrite;

    assign wd_hit       = (TIMEOUT != 0) && (wd == WD_W'(TIMEOUT - 1));
    assign timeout_fire = in_access && wd_hit && !done_ok;

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (accept)
                    state_n = start_req ? ST_REQ : ST_DONE;
                else if (state == ST_DONE && out_ready)
                    state_n = ST_IDLE;
            end
            ST_REQ: begin
                if (done_ok || timeout_fire)
                    state_n = ST_DONE;
                else if (dmem.gnt)
                    state_n = ST_WAIT;
            end
            ST_WAIT: begin
                if (done_ok || timeout_fire)
                    state_n = ST_DONE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // NOTE: the bundle register is reset along with control so WB sees all-zero data after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            ex_q        <= '0;
            load_data_q <= '0;
            wd          <= '0;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wstrb_q     <= '0;
            wdata_q     <= '0;
            misalign_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state      <= state_n;
            misalign_q <= drop;
            err_q      <= timeout_fire;
            if (accept) begin
                ex_q          <= ex_in;
                ex_q.regwrite <= ex_in.regwrite && !drop;
                load_data_q   <= '0;
                wd            <= '0;
                if (start_req) begin
                    req_q   <= 1'b1;
                    we_q    <= ex_in.memwrite;
                    addr_q  <= word_addr(ex_in.result);
                    wstrb_q <= ex_in.memwrite ? al_wstrb : 4'b0000;
                    wdata_q <= ex_in.memwrite ? al_wdata : 32'h0;
                end
            end else if (in_access) begin
                wd <= wd + 1'b1;
                if (load_done)
                    load_data_q <= al_load;
                if (((state == ST_REQ) && dmem.gnt) || timeout_fire)
                    req_q <= 1'b0;
                if (timeout_fire)
                    ex_q.regwrite <= 1'b0;
            end
        end
    end

    assign dmem.req   = req_q;
    assign dmem.we    = we_q;
    assign dmem.addr  = addr_q;
    assign dmem.wstrb = wstrb_q;
    assign dmem.wdata = wdata_q;

    assign wb = '{regwrite:  ex_q.regwrite,
                  memtoreg:  ex_q.memtoreg,
                  rd:        ex_q.rd,
                  result:    ex_q.result,
                  load_data: load_data_q};

    assign mem_wb_data  = wb;
    assign mem_misalign = misalign_q;
    assign mem_err      = err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: two instances, default watchdog and a short (4-cycle) watchdog.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [79:0] ex_mem_data;
    logic        out_ready;

    logic        in_valid, in_ready, out_valid, mem_misalign, mem_err;
    logic [73:0] mem_wb_data;
    logic        in_valid_t, in_ready_t, out_valid_t, mem_misalign_t, mem_err_t;
    logic [73:0] mem_wb_data_t;

    int n_cmp = 0;
    int n_bad = 0;

    mem_stage_if m ();
    mem_stage_if mt ();

    always #5 clk = ~clk;

    mem_stage dut (
        .clk(clk), .rst(rst), .ex_mem_data(ex_mem_data), .in_valid(in_valid), .in_ready(in_ready),
        .dmem(m), .mem_wb_data(mem_wb_data), .out_valid(out_valid), .out_ready(out_ready),
        .mem_misalign(mem_misalign), .mem_err(mem_err)
    );

    mem_stage #(.TIMEOUT(4)) dut_t (
        .clk(clk), .rst(rst), .ex_mem_data(ex_mem_data), .in_valid(in_valid_t), .in_ready(in_ready_t),
        .dmem(mt), .mem_wb_data(mem_wb_data_t), .out_valid(out_valid_t), .out_ready(out_ready),
        .mem_misalign(mem_misalign_t), .mem_err(mem_err_t)
    );

    function automatic logic [79:0] make_ex(input logic mw, input logic mr, input logic rw,
                                            input logic [3:0] m2r, input logic [2:0] mode,
                                            input logic us, input logic [31:0] d2,
                                            input logic [4:0] rd, input logic [31:0] res);
        return {mw, mr, rw, m2r, mode, us, d2, rd, res};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; tick; tick; rst = 1'b0;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        n_cmp++; if (m.req !== 1'b0) begin n_bad++; $display("FAIL reset_req got=%b exp=0", m.req); end
        n_cmp++; if (m.we !== 1'b0) begin n_bad++; $display("FAIL reset_we got=%b exp=0", m.we); end
        n_cmp++; if (m.wstrb !== 4'h0) begin n_bad++; $display("FAIL reset_wstrb got=%b exp=0000", m.wstrb); end
        n_cmp++; if (m.addr !== 32'h0) begin n_bad++; $display("FAIL reset_addr got=%h exp=0", m.addr); end
        n_cmp++; if (m.wdata !== 32'h0) begin n_bad++; $display("FAIL reset_wdata got=%h exp=0", m.wdata); end
        n_cmp++; if (mem_wb_data !== 74'h0) begin n_bad++; $display("FAIL reset_wb got=%h exp=0", mem_wb_data); end
        n_cmp++; if (mem_misalign !== 1'b0) begin n_bad++; $display("FAIL reset_misalign got=%b exp=0", mem_misalign); end
        n_cmp++; if (mem_err !== 1'b0) begin n_bad++; $display("FAIL reset_err got=%b exp=0", mem_err); end
        tick;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL idle_out_valid got=%b exp=0", out_valid); end
    endtask

    task automatic test_alu;
        logic [73:0] exp;
        exp = {1'b1, 4'h1, 5'd7, 32'h0000_1234, 32'h0};
        ex_mem_data = make_ex(1'b0, 1'b0, 1'b1, 4'h1, MODE_W, 1'b0, 32'h0, 5'd7, 32'h0000_1234);
        in_valid = 1'b1; out_ready = 1'b0;
        tick; in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL alu_out_valid got=%b exp=1", out_valid); end
        n_cmp++; if (mem_wb_data !== exp) begin n_bad++; $display("FAIL alu_bundle got=%h exp=%h", mem_wb_data, exp); end
        n_cmp++; if (m.req !== 1'b0) begin n_bad++; $display("FAIL alu_no_req got=%b exp=0", m.req); end
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL alu_stall got=%b exp=0", in_ready); end
        ex_mem_data = '0;
        tick;
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL alu_hold_valid got=%b exp=1", out_valid); end
        n_cmp++; if (mem_wb_data !== exp) begin n_bad++; $display("FAIL alu_hold_bundle got=%h exp=%h", mem_wb_data, exp); end
        out_ready = 1'b1; #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL alu_ready_done got=%b exp=1", in_ready); end
        tick;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL alu_to_idle got=%b exp=0", out_valid); end
    endtask

    task automatic test_back_to_back;
        out_ready = 1'b1;
        ex_mem_data = make_ex(1'b0, 1'b0, 1'b1, 4'h0, MODE_W, 1'b0, 32'h0, 5'd1, 32'h0000_000A);
        in_valid = 1'b1;
        tick;
        n_cmp++; if (mem_wb_data[63:32] !== 32'hA || out_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_first got=%h/%b exp=0000000a/1", mem_wb_data[63:32], out_valid); end
        ex_mem_data = make_ex(1'b0, 1'b0, 1'b1, 4'h0, MODE_W, 1'b0, 32'h0, 5'd2, 32'h0000_000B);
        tick; in_valid = 1'b0;
        n_cmp++; if (mem_wb_data[63:32] !== 32'hB || out_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_second got=%h/%b exp=0000000b/1", mem_wb_data[63:32], out_valid); end
        tick;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_idle got=%b exp=0", out_valid); end
    endtask

    task automatic test_store(input logic mr, input logic [2:0] mode, input logic [31:0] addr,
                              input logic [31:0] d2, input logic [31:0] exp_addr,
                              input logic [3:0] exp_strb, input logic [31:0] exp_wdata);
        ex_mem_data = make_ex(1'b1, mr, 1'b0, 4'h0, mode, 1'b0, d2, 5'd0, addr);
        in_valid = 1'b1; out_ready = 1'b1;
        tick; in_valid = 1'b0;
        n_cmp++; if (m.req !== 1'b1 || m.we !== 1'b1) begin n_bad++; $display("FAIL st_req_we got=%b%b exp=11", m.req, m.we); end
        n_cmp++; if (m.addr !== exp_addr) begin n_bad++; $display("FAIL st_addr got=%h exp=%h", m.addr, exp_addr); end
        n_cmp++; if (m.wstrb !== exp_strb) begin n_bad++; $display("FAIL st_wstrb got=%b exp=%b", m.wstrb, exp_strb); end
        n_cmp++; if (m.wdata !== exp_wdata) begin n_bad++; $display("FAIL st_wdata got=%h exp=%h", m.wdata, exp_wdata); end
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL st_stall got=%b exp=0", in_ready); end
        m.gnt = 1'b1;
        tick; m.gnt = 1'b0;
        n_cmp++; if (m.req !== 1'b0 || out_valid !== 1'b1) begin n_bad++; $display("FAIL st_done got req=%b ov=%b exp req=0 ov=1", m.req, out_valid); end
        tick;
    endtask

    task automatic test_load(input logic us, input logic [2:0] mode, input logic [31:0] addr,
                             input logic [31:0] rdata, input logic [31:0] exp_ld);
        logic [73:0] exp;
        exp = {1'b1, 4'h2, 5'd9, addr, exp_ld};
        ex_mem_data = make_ex(1'b0, 1'b1, 1'b1, 4'h2, mode, us, 32'h0, 5'd9, addr);
        in_valid = 1'b1; out_ready = 1'b1;
        tick; in_valid = 1'b0;
        n_cmp++; if (m.req !== 1'b1 || m.we !== 1'b0) begin n_bad++; $display("FAIL ld_req_we got=%b%b exp=10", m.req, m.we); end
        m.gnt = 1'b1; m.rvalid = 1'b1; m.rdata = rdata;
        tick; m.gnt = 1'b0; m.rvalid = 1'b0;
        n_cmp++; if (out_valid !== 1'b1 || mem_wb_data !== exp) begin n_bad++; $display("FAIL ld_bundle got=%h ov=%b exp=%h", mem_wb_data, out_valid, exp); end
        tick;
    endtask

    task automatic test_lw_wait;
        ex_mem_data = make_ex(1'b0, 1'b1, 1'b1, 4'h0, MODE_W, 1'b0, 32'h0, 5'd5, 32'h0000_3000);
        in_valid = 1'b1; out_ready = 1'b1;
        tick; in_valid = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            m.gnt = (i == 2); m.rvalid = (i == 5); m.rdata = 32'hDEAD_BEEF;
            n_cmp++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin n_bad++; $display("FAIL lw_stall cyc=%0d got ir=%b ov=%b exp 0 0", i, in_ready, out_valid); end
            n_cmp++; if (m.req !== (i <= 2)) begin n_bad++; $display("FAIL lw_req cyc=%0d got=%b exp=%b", i, m.req, (i <= 2)); end
            tick;
        end
        m.gnt = 1'b0; m.rvalid = 1'b0;
        n_cmp++; if (out_valid !== 1'b1 || mem_wb_data[31:0] !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL lw_done got ov=%b ld=%h exp 1 deadbeef", out_valid, mem_wb_data[31:0]); end
        tick;
    endtask

    task automatic test_misalign;
        logic [73:0] exp;
        exp = {1'b0, 4'h1, 5'd4, 32'h0000_4001, 32'h0};
        ex_mem_data = make_ex(1'b0, 1'b1, 1'b1, 4'h1, MODE_H, 1'b0, 32'h0, 5'd4, 32'h0000_4001);
        in_valid = 1'b1; out_ready = 1'b1;
        tick; in_valid = 1'b0;
        n_cmp++; if (m.req !== 1'b0) begin n_bad++; $display("FAIL mis_no_req got=%b exp=0", m.req); end
        n_cmp++; if (mem_misalign !== 1'b1 || out_valid !== 1'b1) begin n_bad++; $display("FAIL mis_pulse got mis=%b ov=%b exp 1 1", mem_misalign, out_valid); end
        n_cmp++; if (mem_wb_data !== exp) begin n_bad++; $display("FAIL mis_bundle got=%h exp=%h", mem_wb_data, exp); end
        tick;
        n_cmp++; if (mem_misalign !== 1'b0 || out_valid !== 1'b0) begin n_bad++; $display("FAIL mis_end got mis=%b ov=%b exp 0 0", mem_misalign, out_valid); end
        ex_mem_data = make_ex(1'b1, 1'b0, 1'b0, 4'h0, MODE_W, 1'b0, 32'h1111_2222, 5'd0, 32'h0000_4002);
        in_valid = 1'b1;
        tick; in_valid = 1'b0;
        n_cmp++; if (m.req !== 1'b0 || mem_misalign !== 1'b1) begin n_bad++; $display("FAIL mis_sw got req=%b mis=%b exp 0 1", m.req, mem_misalign); end
        tick;
    endtask

    task automatic test_timeout;
        ex_mem_data = make_ex(1'b0, 1'b1, 1'b1, 4'h0, MODE_W, 1'b0, 32'h0, 5'd1, 32'h0000_7000);
        in_valid_t = 1'b1; out_ready = 1'b1;
        tick; in_valid_t = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            n_cmp++; if (mt.req !== 1'b1 || mem_err_t !== 1'b0 || out_valid_t !== 1'b0) begin n_bad++; $display("FAIL wd_pending cyc=%0d got req=%b err=%b ov=%b exp 1 0 0", i, mt.req, mem_err_t, out_valid_t); end
            tick;
        end
        n_cmp++; if (mem_err_t !== 1'b1 || mt.req !== 1'b0) begin n_bad++; $display("FAIL wd_abort got err=%b req=%b exp 1 0", mem_err_t, mt.req); end
        n_cmp++; if (out_valid_t !== 1'b1 || mem_wb_data_t[73] !== 1'b0) begin n_bad++; $display("FAIL wd_done got ov=%b rw=%b exp 1 0", out_valid_t, mem_wb_data_t[73]); end
        mt.gnt = 1'b1; mt.rvalid = 1'b1; mt.rdata = 32'h5555_5555;
        tick; mt.gnt = 1'b0; mt.rvalid = 1'b0;
        n_cmp++; if (mem_err_t !== 1'b0 || out_valid_t !== 1'b0 || mt.req !== 1'b0) begin n_bad++; $display("FAIL wd_late got err=%b ov=%b req=%b exp 0 0 0", mem_err_t, out_valid_t, mt.req); end
    endtask

    task automatic test_reset_in_wait;
        ex_mem_data = make_ex(1'b0, 1'b1, 1'b1, 4'h3, MODE_W, 1'b0, 32'h0, 5'd2, 32'h0000_7100);
        in_valid_t = 1'b1; out_ready = 1'b1;
        tick; in_valid_t = 1'b0;
        mt.gnt = 1'b1;
        tick; mt.gnt = 1'b0;
        n_cmp++; if (in_ready_t !== 1'b0 || mt.req !== 1'b0) begin n_bad++; $display("FAIL rw_wait got ir=%b req=%b exp 0 0", in_ready_t, mt.req); end
        rst = 1'b1;
        tick; rst = 1'b0;
        n_cmp++; if (in_ready_t !== 1'b1 || out_valid_t !== 1'b0 || mt.req !== 1'b0) begin n_bad++; $display("FAIL rw_idle got ir=%b ov=%b req=%b exp 1 0 0", in_ready_t, out_valid_t, mt.req); end
        n_cmp++; if (mem_wb_data_t !== 74'h0) begin n_bad++; $display("FAIL rw_discard got=%h exp=0", mem_wb_data_t); end
        mt.rvalid = 1'b1; mt.rdata = 32'hFFFF_FFFF;
        tick; mt.rvalid = 1'b0;
        n_cmp++; if (out_valid_t !== 1'b0 || mem_wb_data_t !== 74'h0) begin n_bad++; $display("FAIL rw_stray_rvalid got ov=%b wb=%h exp 0 0", out_valid_t, mem_wb_data_t); end
    endtask

    initial begin
        rst = 1'b1; ex_mem_data = '0; out_ready = 1'b1;
        in_valid = 1'b0; in_valid_t = 1'b0;
        m.gnt = 1'b0; m.rvalid = 1'b0; m.rdata = '0;
        mt.gnt = 1'b0; mt.rvalid = 1'b0; mt.rdata = '0;
        test_reset;
        test_alu;
        test_back_to_back;
        test_store(1'b0, MODE_B, 32'h0000_1003, 32'h0000_00AB, 32'h0000_1000, 4'b1000, 32'hABAB_ABAB);
        test_store(1'b0, MODE_H, 32'h0000_6002, 32'h1234_CAFE, 32'h0000_6000, 4'b1100, 32'hCAFE_CAFE);
        test_store(1'b1, MODE_W, 32'h0000_5004, 32'h89AB_CDEF, 32'h0000_5004, 4'b1111, 32'h89AB_CDEF);
        test_load(1'b0, MODE_B, 32'h0000_2001, 32'h0000_F000, 32'hFFFF_FFF0);
        test_load(1'b1, MODE_B, 32'h0000_2001, 32'h0000_F000, 32'h0000_00F0);
        test_load(1'b0, MODE_H, 32'h0000_2002, 32'h8001_0000, 32'hFFFF_8001);
        test_load(1'b1, MODE_H, 32'h0000_2002, 32'h8001_0000, 32'h0000_8001);
        test_lw_wait;
        test_misalign;
        test_timeout;
        test_reset_in_wait;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
